// File: rtl/rca_pkg.sv
// rca_pkg
//   Shared definitions for the pipelined ripple-carry adder/subtractor.
//   - MODE_ADD / MODE_SUB : encoding of the in_mode input.
//   - addsub_res_t        : {ovf, cout, sum} bundle returned by ref_addsub.
//   - ref_addsub()        : plain-arithmetic reference for widths 1..63. It is
//                           meant for benches and assertions and has no
//                           hardware counterpart in the datapath.
package rca_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [63:0] sum;
    } addsub_res_t;

    function automatic addsub_res_t ref_addsub(
        input int          width,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic        cin,
        input logic        mode
    );
        addsub_res_t res;
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bb;
        logic        c0;
        logic [5:0]  msb;
        mask = (64'd1 << width) - 64'd1;
        am   = a & mask;
        bb   = (mode == MODE_SUB) ? (~b & mask) : (b & mask);
        c0   = (mode == MODE_SUB) ? 1'b1 : cin;
        full = {1'b0, am} + {1'b0, bb} + {64'd0, c0};
        msb  = 6'(width - 1);
        res.sum  = full[63:0] & mask;
        res.cout = full[7'(width)];
        // Signed overflow: both addends share a sign that the result lacks.
        res.ovf  = (am[msb] == bb[msb]) && (res.sum[msb] != am[msb]);
        return res;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk
//   Combinational CHUNK-bit ripple chain of full-adder cells.
//   Ports:
//     a, b      in  CHUNK  addend bits
//     cin       in  1      carry into bit 0
//     s         out CHUNK  sum bits
//     cout      out 1      carry out of bit CHUNK-1
//     c_msb_in  out 1      carry into bit CHUNK-1 (used for signed overflow)
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// pipelined_rca_addsub
//   Pipelined ripple-carry adder/subtractor with a valid/ready stream on both
//   sides. The WIDTH-bit chain is cut into STAGES = WIDTH/CHUNK segments, one
//   register stage each; latency is STAGES cycles, throughput one beat/cycle.
//   Ports:
//     clk, rst_n                 clock (rising edge), async active-low reset
//     in_valid / in_ready        operand handshake (in_ready = global advance)
//     in_a, in_b  [WIDTH]        operands
//     in_cin                     carry-in, ADD only
//     in_mode                    0 = ADD, 1 = SUB (A - B)
//     out_valid / out_ready      result handshake
//     out_sum     [WIDTH]        result, modulo 2^WIDTH
//     out_cout                   carry out of MSB (SUB: 1 = no borrow)
//     out_ovf                    signed overflow
module pipelined_rca_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
        $error("pipelined_rca_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic             c0;

    // Mode is fully absorbed here (b' and c0), so nothing downstream needs it.
    assign b_cond = (in_mode == MODE_SUB) ? ~in_b : in_b;
    assign c0     = (in_mode == MODE_SUB) ? 1'b1 : in_cin;

    // Whole pipeline moves as one shift register, bubbles included.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Each stage register x_q holds the finished sum bits below its boundary
    // and the still-untouched A bits above it, so the word reaches the last
    // stage fully deskewed. The b' bits shrink by one chunk per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * CHUNK;
        localparam int BW = WIDTH - LO;

        logic [WIDTH-1:0] x_src;
        logic [WIDTH-1:0] x_d;
        logic [WIDTH-1:0] x_q;
        logic [BW-1:0]    b_src;
        logic             c_src;
        logic             v_src;
        logic [CHUNK-1:0] s_c;
        logic             c_o;
        logic             c_m;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_head
            assign x_src = in_a;
            assign b_src = b_cond;
            assign c_src = c0;
            assign v_src = in_valid;
        end else begin : g_body
            assign x_src = g_stg[k-1].x_q;
            assign b_src = g_stg[k-1].g_fwd.b_q;
            assign c_src = g_stg[k-1].c_q;
            assign v_src = g_stg[k-1].v_q;
        end

        rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (x_src[LO +: CHUNK]),
            .b        (b_src[CHUNK-1:0]),
            .cin      (c_src),
            .s        (s_c),
            .cout     (c_o),
            .c_msb_in (c_m)
        );

        always_comb begin
            x_d            = x_src;
            x_d[LO +: CHUNK] = s_c;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                x_q <= x_d;
                c_q <= c_o;
                v_q <= v_src;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [BW-CHUNK-1:0] b_q;
            // Carry into a chunk MSB only matters for the real MSB.
            logic                c_msb_unused;
            assign c_msb_unused = c_m;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (adv) begin
                    b_q <= b_src[BW-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_m ^ c_o;
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign out_sum   = g_stg[STAGES-1].x_q;
    assign out_cout  = g_stg[STAGES-1].c_q;
    assign out_ovf   = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
module tb_pipelined_rca_addsub;
    import rca_pkg::*;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          lat_chk = 0;
    bit          run4 = 0;
    int          pops16 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit instance
    logic        v16 = 1'b0, cin16 = 1'b0, mode16 = 1'b0, ordy16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        r16, ov16, cout16, ovf16;
    logic [15:0] sum16;
    // 4-bit instance
    logic        v4 = 1'b0, cin4 = 1'b0, mode4 = 1'b0, ordy4 = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        r4, ov4, cout4, ovf4;
    logic [3:0]  sum4;

    exp_t q16[$];
    exp_t q4[$];

    pipelined_rca_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
        .in_a(a16), .in_b(b16), .in_cin(cin16), .in_mode(mode16),
        .out_valid(ov16), .out_ready(ordy16), .out_sum(sum16),
        .out_cout(cout16), .out_ovf(ovf16)
    );

    pipelined_rca_addsub #(.WIDTH(4), .CHUNK(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .in_a(a4), .in_b(b4), .in_cin(cin4), .in_mode(mode4),
        .out_valid(ov4), .out_ready(ordy4), .out_sum(sum4),
        .out_cout(cout4), .out_ovf(ovf4)
    );

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input bit cin, input bit mode, input int unsigned c);
        exp_t   e;
        longint full, half, sa, sb, r, sr;
        full = longint'(1) << w;
        half = full / 2;
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        if (mode == MODE_SUB) begin
            r  = a - b;
            sr = sa - sb;
            e.cout = (a >= b);
        end else begin
            r  = a + b + longint'(cin);
            sr = sa + sb + longint'(cin);
            e.cout = (r >= full);
        end
        e.sum = 16'(r & (full - 1));
        e.ovf = (sr < -half) || (sr >= half);
        e.cyc = c;
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor, 16-bit
    initial begin
        bit          stalled;
        logic [15:0] hs;
        logic        hc, ho;
        exp_t        e;
        stalled = 0;
        hs = '0; hc = 0; ho = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (v16 && r16)
                    q16.push_back(model(16, longint'(a16), longint'(b16), cin16, mode16, cyc));
                if (stalled) begin
                    check("hold_valid16", ov16, 1);
                    check("hold_sum16", sum16, hs);
                    check("hold_cout16", cout16, hc);
                    check("hold_ovf16", ovf16, ho);
                end
                if (ov16 && !ordy16) begin
                    check("stall_in_ready16", r16, 0);
                    stalled = 1;
                    hs = sum16; hc = cout16; ho = ovf16;
                end else begin
                    stalled = 0;
                    if (ov16) begin
                        pops16++;
                        if (q16.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected16: output with nothing pending, sum=%h", sum16);
                        end else begin
                            e = q16.pop_front();
                            check("sum16", sum16, e.sum);
                            check("cout16", cout16, e.cout);
                            check("ovf16", ovf16, e.ovf);
                            if (lat_chk) check("latency16", longint'(cyc - e.cyc), 4);
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor, 4-bit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (v4 && r4)
                    q4.push_back(model(4, longint'(a4), longint'(b4), cin4, mode4, cyc));
                if (ov4 && ordy4) begin
                    if (q4.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected4: output with nothing pending, sum=%h", sum4);
                    end else begin
                        e = q4.pop_front();
                        check("sum4", sum4, longint'(e.sum));
                        check("cout4", cout4, e.cout);
                        check("ovf4", ovf4, e.ovf);
                    end
                end
            end
        end
    end

    // Random downstream back-pressure for the exhaustive run
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (run4) ordy4 = ($urandom_range(0, 2) != 0);
            else ordy4 = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drivers: called just after a rising edge; hold the beat until accepted.
    task automatic send16(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic mode);
        bit ok;
        ok = 0;
        v16 = 1'b1; a16 = a; b16 = b; cin16 = cin; mode16 = mode;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = r16;
        end
        if (!ok) check("send16_timeout", 0, 1);
        @(posedge clk);
        #1;
        v16 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic mode);
        bit ok;
        ok = 0;
        v4 = 1'b1; a4 = a; b4 = b; cin4 = cin; mode4 = mode;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = r4;
        end
        if (!ok) check("send4_timeout", 0, 1);
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic drain16();
        for (int i = 0; i < 300 && q16.size() != 0; i++) @(posedge clk);
        #1;
        check("drain16", q16.size(), 0);
    endtask

    task automatic drain4();
        for (int i = 0; i < 300 && q4.size() != 0; i++) @(posedge clk);
        #1;
        check("drain4", q4.size(), 0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid16", ov16, 0);
        check("reset_sum16", sum16, 0);
        check("reset_out_valid4", ov4, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset16", r16, 1);

        // Directed corner beats, back-to-back, latency checked
        lat_chk = 1;
        send16(16'hFFFF, 16'h0001, 1'b0, MODE_ADD);
        send16(16'h8000, 16'h0001, 1'b0, MODE_SUB);
        send16(16'h0003, 16'h0005, 1'b0, MODE_SUB);
        send16(16'h7FFF, 16'h0000, 1'b1, MODE_ADD);
        send16(16'h7FFF, 16'h0000, 1'b1, MODE_SUB);
        send16(16'h8000, 16'h8000, 1'b0, MODE_ADD);
        send16(16'h0000, 16'h8000, 1'b0, MODE_SUB);
        drain16();

        // Random back-to-back beats
        for (int i = 0; i < 24; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain16();
        lat_chk = 0;

        // 8 beats with out_ready low for cycles 5..7
        base = pops16;
        fork
            for (int i = 0; i < 8; i++)
                send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            begin
                repeat (5) @(posedge clk);
                #1 ordy16 = 1'b0;
                repeat (3) @(posedge clk);
                #1 ordy16 = 1'b1;
            end
        join
        drain16();
        check("stall_result_count", pops16 - base, 8);

        // Reset while beats are in flight and an output is stalled
        ordy16 = 1'b0;
        for (int i = 0; i < 4; i++)
            send16(16'h1234 + 16'(i), 16'h0101, 1'b0, MODE_ADD);
        repeat (2) @(posedge clk);
        #1;
        check("stalled_before_reset", ov16, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", ov16, 0);
        check("midreset_sum", sum16, 0);
        q16.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy16 = 1'b1;
        #1;
        check("ready_after_midreset", r16, 1);
        base = pops16;
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_beat", pops16 - base, 0);

        // Exhaustive 4-bit sweep with random back-pressure
        run4 = 1;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        send4(4'(a), 4'(b), 1'(c), 1'(m));
        run4 = 0;
        drain4();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
